// File: rtl/weather_seq_pkg.sv
// Shared definitions for the weather-station serial sequence scorer.
//   - cfg_addr register map (pattern / length / slope / offset)
//   - reset-time default configuration per channel
package weather_seq_pkg;

    localparam logic [1:0] CFG_PAT   = 2'd0;
    localparam logic [1:0] CFG_LEN   = 2'd1;
    localparam logic [1:0] CFG_SLOPE = 2'd2;
    localparam logic [1:0] CFG_OFF   = 2'd3;

    // Default pattern, newest bit in bit0. Channels without a default are zero.
    function automatic logic [7:0] def_pat(input int ch);
        case (ch)
            0:       return 8'b0000_0111;
            1:       return 8'b0000_0010;
            2:       return 8'b0000_0101;
            default: return 8'd0;
        endcase
    endfunction

    // Default pattern length; zero leaves the channel disabled.
    function automatic logic [7:0] def_len(input int ch);
        case (ch)
            0, 1, 2: return 8'd3;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] def_slope(input int ch);
        case (ch)
            0:       return 8'd3;
            1:       return 8'd1;
            2:       return 8'd8;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] def_off(input int ch);
        case (ch)
            0:       return 8'd43;
            1:       return 8'd52;
            2:       return 8'd19;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/wss_match_chan.sv
// One detector channel: holds its programmable pattern, length, slope and
// offset, and compares the pattern against the current bit window.
// Ports:
//   CLK, Reset_n   clock / asynchronous active-low reset (restores defaults)
//   cfg_we/ch/addr/wdata  configuration write bus shared by all channels
//   x_valid        a new serial bit is present this edge
//   window         {history, x}: newest bit in bit0
//   fill           number of valid history bits (saturates at PAT_MAX)
//   hit_next       match result to be registered into hit_vec
//   slope, offset  scoring coefficients of this channel
module wss_match_chan
    import weather_seq_pkg::*;
#(
    parameter int CH      = 0,
    parameter int PAT_MAX = 4,
    parameter int OUT_W   = 8,
    parameter int CH_W    = 2,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_addr,
    input  logic [OUT_W-1:0]   cfg_wdata,
    input  logic               x_valid,
    input  logic [PAT_MAX:0]   window,
    input  logic [LEN_W-1:0]   fill,
    output logic               hit_next,
    output logic [OUT_W-1:0]   slope,
    output logic [OUT_W-1:0]   offset
);

    logic [PAT_MAX-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               sel;
    logic [PAT_MAX:0]   mask;
    logic               fill_ok;
    logic               pat_eq;

    // Reset-time length, clamped like a runtime write would be.
    function automatic logic [LEN_W-1:0] reset_len();
        if (int'(def_len(CH)) > PAT_MAX)
            return LEN_W'(PAT_MAX);
        return LEN_W'(def_len(CH));
    endfunction

    // Out-of-range channel indices never equal CH, so such writes drop out here.
    assign sel = cfg_we && (cfg_ch == CH_W'(CH));

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            pat_r  <= PAT_MAX'(def_pat(CH));
            len_r  <= reset_len();
            slope  <= OUT_W'(def_slope(CH));
            offset <= OUT_W'(def_off(CH));
        end else if (sel) begin
            case (cfg_addr)
                CFG_PAT:   pat_r  <= cfg_wdata[PAT_MAX-1:0];
                CFG_LEN: begin
                    if (cfg_wdata > OUT_W'(PAT_MAX))
                        len_r <= LEN_W'(PAT_MAX);
                    else
                        len_r <= cfg_wdata[LEN_W-1:0];
                end
                CFG_SLOPE: slope  <= cfg_wdata;
                default:   offset <= cfg_wdata;
            endcase
        end
    end

    // Only the newest len_r bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int b = 0; b <= PAT_MAX; b++)
            mask[b] = (b < int'(len_r));
    end

    assign fill_ok = (({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len_r});
    assign pat_eq  = ((window & mask) == ({1'b0, pat_r} & mask));

    // A config write to this channel suppresses its hit on the same edge.
    assign hit_next = x_valid && (len_r != '0) && fill_ok && pat_eq && !sel;

endmodule

// File: rtl/weather_seq_scorer.sv
// Multi-channel serial sequence detector and scorer. Each channel matches a
// programmable, overlapping bit pattern on the serial input; the highest
// matching channel loads out with slope*count+offset one edge later.
// Ports:
//   CLK, Reset_n   clock / asynchronous active-low reset
//   x, x_valid     serial data bit and its qualifier
//   cfg_we, cfg_ch, cfg_addr, cfg_wdata   per-channel configuration write
//   out            score register (mod 2^OUT_W)
//   out_valid      one-cycle pulse when out was updated
//   out_ch         channel that produced out
//   hit_vec        registered per-channel match flags
module weather_seq_scorer
    import weather_seq_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int PAT_MAX = 4,
    parameter int CNT_W   = 8,
    parameter int OUT_W   = 8,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_addr,
    input  logic [OUT_W-1:0]   cfg_wdata,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [CH_W-1:0]    out_ch,
    output logic [NCH-1:0]     hit_vec
);

    localparam int LEN_W = $clog2(PAT_MAX + 1);

    logic [CNT_W-1:0]   count;
    logic [PAT_MAX-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [PAT_MAX:0]   window_p0;
    logic [NCH-1:0]     hit_nxt_p0;
    logic [OUT_W-1:0]   slope_arr [NCH];
    logic [OUT_W-1:0]   off_arr   [NCH];
    logic [CH_W-1:0]    sel_idx_p1;
    logic [OUT_W-1:0]   sel_slope_p1;
    logic [OUT_W-1:0]   sel_off_p1;

    // slope*count+offset, wrapped to OUT_W bits. Only the low OUT_W bits of
    // the product can reach the result, so the product is cut there first.
    function automatic logic [OUT_W-1:0] score_mod(
        input logic [OUT_W-1:0] s,
        input logic [CNT_W-1:0] c,
        input logic [OUT_W-1:0] o
    );
        logic [OUT_W-1:0] prod;
        prod = OUT_W'(s * c);
        return prod + o;
    endfunction

    // Free-running cycle counter, independent of x_valid.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    // ---- Stage p0: history window and per-channel compare ----
    assign window_p0 = {hist, x};

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            hist <= '0;
            fill <= '0;
        end else if (x_valid) begin
            hist <= window_p0[PAT_MAX-1:0];
            if (fill != LEN_W'(PAT_MAX))
                fill <= fill + LEN_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        wss_match_chan #(
            .CH      (i),
            .PAT_MAX (PAT_MAX),
            .OUT_W   (OUT_W),
            .CH_W    (CH_W),
            .LEN_W   (LEN_W)
        ) u_chan (
            .CLK       (CLK),
            .Reset_n   (Reset_n),
            .cfg_we    (cfg_we),
            .cfg_ch    (cfg_ch),
            .cfg_addr  (cfg_addr),
            .cfg_wdata (cfg_wdata),
            .x_valid   (x_valid),
            .window    (window_p0),
            .fill      (fill),
            .hit_next  (hit_nxt_p0[i]),
            .slope     (slope_arr[i]),
            .offset    (off_arr[i])
        );
    end

    // x_valid low yields all-zero hit_next, so hit_vec clears on idle edges.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            hit_vec <= '0;
        else
            hit_vec <= hit_nxt_p0;
    end

    // ---- Stage p1: priority select and score register ----
    always_comb begin
        sel_idx_p1   = '0;
        sel_slope_p1 = slope_arr[0];
        sel_off_p1   = off_arr[0];
        // Ascending scan: the highest set index is the last one to win.
        for (int i = 0; i < NCH; i++) begin
            if (hit_vec[i]) begin
                sel_idx_p1   = CH_W'(i);
                sel_slope_p1 = slope_arr[i];
                sel_off_p1   = off_arr[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (|hit_vec) begin
            out       <= score_mod(sel_slope_p1, count, sel_off_p1);
            out_ch    <= sel_idx_p1;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_weather_seq_scorer.sv
module tb_weather_seq_scorer;
    import weather_seq_pkg::*;

    localparam int NCH     = 3;
    localparam int PAT_MAX = 4;
    localparam int CNT_W   = 8;
    localparam int OUT_W   = 8;
    localparam int CH_W    = 2;

    logic             CLK = 1'b0;
    logic             Reset_n;
    logic             x;
    logic             x_valid;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_addr;
    logic [OUT_W-1:0] cfg_wdata;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic [NCH-1:0]   hit_vec;

    always #5 CLK = ~CLK;

    weather_seq_scorer #(
        .NCH(NCH), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W), .OUT_W(OUT_W)
    ) dut (
        .CLK       (CLK),
        .Reset_n   (Reset_n),
        .x         (x),
        .x_valid   (x_valid),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .out       (out),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .hit_vec   (hit_vec)
    );

    typedef struct packed {
        logic [OUT_W-1:0] val;
        logic [CH_W-1:0]  ch;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every out_valid pulse must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (Reset_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got out=%0d ch=%0d, expected no output (t=%0t)",
                             out, out_ch, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("score_out", int'(out), int'(e.val));
                    check("score_ch", int'(out_ch), int'(e.ch));
                end
            end
        end
    end

    // All stimulus is applied just after a falling edge.
    task automatic send(input logic b);
        x       = b;
        x_valid = 1'b1;
        @(negedge CLK);
        x_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        x_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] addr, input int data);
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_addr  = addr;
        cfg_wdata = OUT_W'(data);
        @(negedge CLK);
        cfg_we    = 1'b0;
    endtask

    task automatic expect_score(input int val, input int ch);
        exp_t e;
        e.val = OUT_W'(val);
        e.ch  = CH_W'(ch);
        exp_q.push_back(e);
    endtask

    // Leaves the bench at a falling edge; the next rising edge is E0 (count_pre=0).
    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n   = 1'b0;
        x         = 1'b0;
        x_valid   = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_addr  = '0;
        cfg_wdata = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_out", int'(out), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_hit_vec", int'(hit_vec), 0);
        Reset_n = 1'b1;

        // 1,1,1 -> ch0 at E2, scored at E3: 3*3+43
        send(1'b1); send(1'b1);
        expect_score(52, 0);
        send(1'b1);
        check("hit_vec_111", int'(hit_vec), 3'b001);
        idle(4);

        // 0,1,0 -> ch1: 1*3+52
        do_reset();
        send(1'b0); send(1'b1);
        expect_score(55, 1);
        send(1'b0);
        idle(4);

        // 1,0,1,0,1 -> ch2@E2 (43), ch1@E3 (4+52), ch2@E4 (8*5+19)
        do_reset();
        send(1'b1); send(1'b0);
        expect_score(43, 2);
        send(1'b1);
        expect_score(56, 1);
        send(1'b0);
        expect_score(59, 2);
        send(1'b1);
        idle(4);

        // ch0 reprogrammed to a single '1'; ch0 and ch2 both hit at E4 -> ch2 wins
        do_reset();
        cfg_write(0, CFG_LEN, 1);
        cfg_write(0, CFG_PAT, 1);
        expect_score(52, 0);
        send(1'b1);
        send(1'b0);
        expect_score(59, 2);
        send(1'b1);
        check("hit_vec_prio", int'(hit_vec), 3'b101);
        idle(4);

        // Out-of-range channel write ignored; ch1 length 15 clamps to 4, pattern 1010
        do_reset();
        cfg_write(3, CFG_LEN, 0);
        cfg_write(1, CFG_PAT, 4'b1010);
        cfg_write(1, CFG_LEN, 15);
        send(1'b1); send(1'b0);
        expect_score(67, 2);
        send(1'b1);
        expect_score(59, 1);
        send(1'b0);
        idle(4);

        // Score wrap: 8*30+19=259 -> 3; counter wrap: count_pre 259 mod 256 = 3 -> 43
        do_reset();
        idle(27);
        send(1'b1); send(1'b0);
        expect_score(3, 2);
        send(1'b1);
        idle(226);
        send(1'b1); send(1'b0);
        expect_score(43, 2);
        send(1'b1);
        idle(4);

        // Reset mid-stream with a non-zero score and full history of ones
        do_reset();
        send(1'b1); send(1'b1);
        expect_score(52, 0);
        send(1'b1);
        send(1'b1);
        Reset_n = 1'b0;
        #1;
        check("midrst_out", int'(out), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_hit_vec", int'(hit_vec), 0);
        @(negedge CLK);
        Reset_n = 1'b1;
        // 1, gap, 1, gap, 1 -> only the third bit completes 111; scored at E5: 3*5+43
        send(1'b1);
        idle(1);
        send(1'b1);
        check("gap_no_early_hit", int'(hit_vec), 0);
        idle(1);
        expect_score(58, 0);
        send(1'b1);
        idle(5);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
